// File: rtl/echo_arb_pkg.sv
// Shared constants and the slot record for the echo request arbiter.
// Slot/tag widths here follow the default NREQ/DATA_W build.
package echo_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = $clog2(NREQ_DEF);

  localparam int              STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } slot_t;

  // Round-robin successor: index n-1 wraps back to 0.
  function automatic int rr_succ(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/echo_req_arbiter_rr_pick.sv
// Round-robin pick: first pending index at or after ptr_i, wrapping at N-1.
// Purely combinational; grant_o is one-hot or zero.
module rr_pick
  import echo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         pend_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  logic         found;
  logic [W-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!found && pend_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
      j = W'(rr_succ(int'(j), N));
    end
  end

endmodule

// File: rtl/echo_req_arbiter.sv
// Round-robin arbiter feeding one registered enq slot (data + source tag).
// Optional per-requester saturating grant counters under `define ARB_STATS_EN.
module echo_req_arbiter
  import echo_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_pend,
  input  logic [NREQ-1:0]         req__ENA,
  input  logic [NREQ*DATA_W-1:0]  req_v,
  output logic [NREQ-1:0]         req__RDY,
  output logic                    out_enq__ENA,
  output logic [DATA_W-1:0]       out_enq_v,
  output logic [$clog2(NREQ)-1:0] out_enq_tag,
  input  logic                    out_enq__RDY,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  input  logic                    stat_clr,
  output logic [STAT_W-1:0]       stat_count
);

  localparam int TAG_W = $clog2(NREQ);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } arb_slot_t;

  arb_slot_t         slot_q, slot_d;
  logic [TAG_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   pick_grant;
  logic [TAG_W-1:0]  pick_idx;
  logic              slot_free;
  logic              drain;
  logic              accept;
  logic [DATA_W-1:0] req_data [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data[g] = req_v[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NREQ)) u_pick (
    .pend_i  (req_pend),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Pass-through: a draining slot can be refilled in the same cycle.
  assign slot_free = !slot_q.valid || out_enq__RDY;
  assign req__RDY  = pick_grant & {NREQ{slot_free}};
  assign accept    = |(req__ENA & req__RDY);
  assign drain     = slot_q.valid && out_enq__RDY;

  assign out_enq__ENA = drain;
  assign out_enq_v    = slot_q.valid ? slot_q.data : '0;
  assign out_enq_tag  = slot_q.valid ? slot_q.tag  : '0;

  always_comb begin
    slot_d = slot_q;
    ptr_d  = ptr_q;
    if (accept) begin
      slot_d.valid = 1'b1;
      slot_d.tag   = pick_idx;
      slot_d.data  = req_data[pick_idx];
      ptr_d        = TAG_W'(rr_succ(int'(pick_idx), NREQ));
    end else if (drain) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_q <= '0;
      ptr_q  <= '0;
    end else begin
      slot_q <= slot_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  // Clear wins over a same-cycle increment; counters stick at STAT_MAX.
  always_ff @(posedge CLK) begin
    if (!nRST || stat_clr) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept && cnt_q[pick_idx] != STAT_MAX) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
    end
  end

  assign stat_count = (int'(stat_sel) < NREQ) ? cnt_q[stat_sel] : '0;
`else
  logic stat_unused;
  assign stat_unused = ^{stat_sel, stat_clr};
  assign stat_count  = '0;
`endif

`ifndef SYNTHESIS
  a_ena_needs_rdy: assert property (@(posedge CLK) disable iff (!nRST)
    ((req__ENA & ~req__RDY) == '0))
    else $error("echo_req_arbiter: req__ENA without req__RDY");

  a_ena_onehot: assert property (@(posedge CLK) disable iff (!nRST)
    $onehot0(req__ENA))
    else $error("echo_req_arbiter: multiple req__ENA bits");
`endif

endmodule

// File: doc/echo_req_arbiter.md
Name: echo_req_arbiter

Overview:
- Round-robin arbiter that shares one downstream guarded enq method (the echo request FIFO's enq) among NREQ requesters.
- Each requester presents a pending flag and uses the standard __ENA/__RDY guarded-method handshake.
- A one-entry registered output slot carries data plus a source tag, so the downstream sees registered ENA/data and can route responses by tag.
- Sits between multiple client portals and the shared echo datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DATA_W, 32, payload width.
- TAG_W, $clog2(NREQ), source tag width. Localparam; not overridable.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- req_pend  in  NREQ  requester i has a request pending. Must not depend on req__RDY.
- req__ENA  in  NREQ  requester i fires enq. Legal only when req__RDY[i]=1.
- req_v  in  NREQ*DATA_W  payloads; slice i = [i*DATA_W +: DATA_W].
- req__RDY  out  NREQ  one-hot-or-zero grant.
- out$enq__ENA  out  1  downstream enq fire.
- out$enq_v  out  DATA_W  payload to downstream.
- out$enq_tag  out  TAG_W  index of the originating requester.
- out$enq__RDY  in  1  downstream can accept.
- stat_sel  in  TAG_W  counter select (ARB_STATS_EN).
- stat_clr  in  1  clear all counters (ARB_STATS_EN).
- stat_count  out  16  selected grant count (ARB_STATS_EN).

Behaviour:
- State: slot_valid, slot_data[DATA_W], slot_tag[TAG_W], ptr[TAG_W].
- Reset (nRST=0 at posedge): slot_valid=0, slot_data=0, slot_tag=0, ptr=0, counters=0. All outputs then read 0.
- Reset asserted mid-transfer discards the slot contents. No replay.
- slot_free = !slot_valid | out$enq__RDY. This is pass-through: a drain and a refill can happen in the same cycle.
- Grant selection (combinational):
  - Pick the first i with req_pend[i]=1, searching ptr, ptr+1, …, wrapping at NREQ-1 back to 0.
  - req__RDY = onehot(i) & {NREQ{slot_free}}.
  - If no req_pend bit is set, req__RDY = 0.
- req__RDY never depends on req__ENA.
- Accept on req__ENA[i] & req__RDY[i]:
  - slot_valid<=1, slot_data<=req_v[i], slot_tag<=i.
  - ptr <= (i==NREQ-1) ? 0 : i+1.
- Without an accept, ptr holds. A pend that drops without firing does not advance ptr.
- Downstream interface:
  - out$enq__ENA = slot_valid & out$enq__RDY.
  - out$enq_v = slot_valid ? slot_data : 0.
  - out$enq_tag = slot_valid ? slot_tag : 0.
- On out$enq__ENA with no new accept: slot_valid<=0.
- On drain and accept in the same cycle: slot_valid stays 1 and the slot holds the new data.
- Latency: accept at edge t makes the data visible on out$enq_* at t+1. It fires the first cycle after that in which out$enq__RDY=1.
- Throughput: 1 per cycle while the downstream stays ready.
- Backpressure: while slot_valid & !out$enq__RDY, all req__RDY=0 and the slot is held stable.
- Fairness: once granted, requester i is not granted again before every other pending requester has been served once.
- Protocol violations:
  - req__ENA[i] while req__RDY[i]=0: simulation assertion error. RTL ignores the bit.
  - More than one req__ENA bit set: simulation assertion error.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - NREQ saturating 16-bit counters; cnt[i] increments on each accept from requester i and sticks at 16'hFFFF.
  - stat_clr=1 zeroes all counters. It takes priority over an increment in the same cycle.
  - stat_count = cnt[stat_sel], combinational read. stat_sel >= NREQ reads 0.
- Undefined:
  - Ports remain present; stat_count is tied to 0 and stat_sel/stat_clr are ignored.
  - No counter flops are instantiated.

Decomposition:
- Package echo_arb_pkg holds:
  - the default NREQ/DATA_W constants;
  - STAT_W=16 and STAT_MAX=16'hFFFF;
  - a typedef for the slot record {valid, tag, data}.
- Sub-module rr_pick: combinational, parameter N; inputs pend[N], ptr; outputs grant one-hot and idx. Instantiated once.

Test Plan:
- Single requester: reset, req_pend=4'b0100, fire with 0xDEADBEEF, out$enq__RDY=1 → req__RDY=4'b0100; next cycle out$enq__ENA=1, v=0xDEADBEEF, tag=2; ptr=3.
- All pending, downstream always ready, 8 fires → tags 0,1,2,3,0,1,2,3 on consecutive cycles, one transfer per cycle.
- Backpressure: slot holds 0x11 (tag 1), out$enq__RDY=0 for 5 cycles → req__RDY=0 throughout, out$enq_v stable at 0x11; when RDY rises, 0x11 fires and a new accept is taken the same cycle.
- Pend without fire: req_pend=4'b1000 for 3 cycles, no ENA → ptr stays 0, nothing output; then fire → tag 3, ptr wraps to 0.
- Reset mid-operation: slot_valid=1 with 0x55, nRST=0 for one edge → out$enq__ENA=0, out$enq_v=0, req__RDY follows pend from ptr 0.
- ARB_STATS_EN: 70000 fires from requester 1 → stat_sel=1 reads 0xFFFF; stat_clr → 0; stat_clr and a fire in the same cycle → 0.
